// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, widths and address checking for the data-memory responder.
//   DATA_W   word width
//   BE_W     byte-enable width
//   state_t  responder FSM states
//   addr_err misaligned or out-of-range byte address
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 synchronous single-port storage, per-byte writes, registered read.
//   clk      clock
//   i_en     access enable (write when i_we, else read)
//   i_we     1 = write enabled bytes, 0 = read word into o_rdata
//   i_be     byte enables, bit b covers bits [8b+7:8b]
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  read data, held until the next read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word data memory behind a valid/ready handshake with LATENCY wait states.
//   Build option: define DMEM_BYTE_LANE_EN to honour i_req_be; otherwise stores write full words.
//   clk          clock
//   rst          asynchronous active-high reset
//   i_req_valid  request present
//   o_req_ready  responder can accept
//   i_req_we     1 = store, 0 = load
//   i_req_addr   byte address
//   i_req_wdata  store data
//   i_req_be     byte enables
//   o_rsp_valid  response present
//   i_rsp_ready  response consumed
//   o_rsp_rdata  load data, 0 for stores and errors
//   o_rsp_err    misaligned or out-of-range access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [31:0]       i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [BE_W-1:0]   i_req_be,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd_ok;
`ifdef DMEM_BYTE_LANE_EN
    logic [BE_W-1:0]   r_be;
`endif
    logic              w_accept, w_commit, w_we, w_err;
    logic [31:0]       w_addr;
    logic [DATA_W-1:0] w_wdata, w_q;
    logic [BE_W-1:0]   w_be;

    // With zero wait states the array is accessed on the acceptance edge itself,
    // so the live request feeds the array in IDLE and the captured one afterwards.
    assign w_accept = (r_state == S_IDLE) && i_req_valid && o_req_ready;
    assign w_we     = (r_state == S_IDLE) ? i_req_we    : r_we;
    assign w_addr   = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
`ifdef DMEM_BYTE_LANE_EN
    assign w_be     = (r_state == S_IDLE) ? i_req_be    : r_be;
`else
    // Every store writes the full word regardless of the requested lanes.
    assign w_be     = i_req_be | {BE_W{1'b1}};
`endif
    assign w_err    = addr_err(w_addr, DEPTH);
    // w_commit marks the edge that enters RESP: the only edge the array is touched.
    assign w_commit = (w_accept && LATENCY == 0) || (r_state == S_WAIT && r_cnt == LAST);

    // Read data is only exposed for a successful load; the array holds it stable.
    assign o_rsp_rdata = r_rd_ok ? w_q : '0;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .i_en    (w_commit && !w_err),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_addr[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
`ifdef DMEM_BYTE_LANE_EN
            r_be        <= '0;
`endif
            r_rd_ok     <= 1'b0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_req_ready <= !w_accept;
                    if (w_accept) begin
                        r_we    <= i_req_we;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
`ifdef DMEM_BYTE_LANE_EN
                        r_be    <= i_req_be;
`endif
                        r_cnt   <= '0;
                        r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == LAST) r_state <= S_RESP;
                    else r_cnt <= r_cnt + 4'd1;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        r_rd_ok     <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= w_err;
                r_rd_ok     <= !w_err && !w_we;
            end
        end
    end
endmodule
